// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared FSM encoding and geometry helpers for the camera capture path
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYNC,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    function automatic int pix_w(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

    function automatic int pix_per_word(input int word_w, input int data_w, input int bytes_per_pix);
        return word_w / (data_w * bytes_per_pix);
    endfunction

endpackage

// File: rtl/cam_pin_sync.sv
// rtl/cam_pin_sync.sv - camera pin synchroniser with PCLK rising-edge strobe
module cam_pin_sync #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              pclk_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              stb_o,
    output logic              vsync_o,
    output logic              href_o,
    output logic [DATA_W-1:0] data_o
);

    logic [2:0]        pclk_q;
    logic [1:0]        vsync_q;
    logic [1:0]        href_q;
    logic [DATA_W-1:0] data_s1_q;
    logic [DATA_W-1:0] data_s2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pclk_q    <= '0;
            vsync_q   <= '0;
            href_q    <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            pclk_q    <= {pclk_q[1:0], pclk_i};
            vsync_q   <= {vsync_q[0], vsync_i};
            href_q    <= {href_q[0], href_i};
            data_s1_q <= data_i;
            data_s2_q <= data_s1_q;
        end
    end

    // pclk_q[1] is stage 2 (aligned with the other pins), pclk_q[2] is the extra edge-detect stage
    assign stb_o   = pclk_q[1] & ~pclk_q[2];
    assign vsync_o = vsync_q[1];
    assign href_o  = href_q[1];
    assign data_o  = data_s2_q;

endmodule

// File: rtl/camera_capture_v2.sv
// rtl/camera_capture_v2.sv - camera frame capture: pixel assembly, word packing, capture FSM
module camera_capture_v2
    import camera_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int WORD_W        = 32,
    parameter int DEPTH         = 38400,
    parameter int ADDR_W        = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cap_start,
    input  logic              cap_continuous,
    input  logic              cap_stop,
    input  logic              cap_ack,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [DATA_W-1:0] cam_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              frame_pulse,
    output logic              cap_overflow,
    output logic [ADDR_W:0]   frame_words
);

    localparam int PIX_W  = pix_w(DATA_W, BYTES_PER_PIX);
    localparam int PPW    = pix_per_word(WORD_W, DATA_W, BYTES_PER_PIX);
    localparam int BC_W   = clog2(BYTES_PER_PIX + 1);
    localparam int LANE_W = clog2(PPW + 1);
    localparam int IDX_W  = ADDR_W + 1;

    logic              stb;
    logic              vsync_s;
    logic              href_s;
    logic [DATA_W-1:0] data_s;

    cap_state_e        state_q, state_d;
    logic              cont_q, cont_d;
    logic              stop_q, stop_d;
    logic              flush_q, flush_d;
    logic              drop_q, drop_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ram_we_q, ram_we_d;
    logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              frame_pulse_q, frame_pulse_d;
    logic              overflow_q, overflow_d;
    logic [IDX_W-1:0]  frame_words_q, frame_words_d;

    logic [PIX_W-1:0]  pix_next;
    logic [WORD_W-1:0] word_ins;
    logic [IDX_W-1:0]  words_now;
    logic              finish;

    cam_pin_sync #(.DATA_W(DATA_W)) u_pin_sync (
        .clk_i   (HCLK),
        .reset_i (HRESET),
        .pclk_i  (cam_pclk),
        .vsync_i (cam_vsync),
        .href_i  (cam_href),
        .data_i  (cam_data),
        .stb_o   (stb),
        .vsync_o (vsync_s),
        .href_o  (href_s),
        .data_o  (data_s)
    );

    // Earlier bytes shift toward the MSBs, so the first byte of a pixel ends up on top
    assign pix_next  = PIX_W'({pix_q, data_s});
    assign word_ins  = word_q | (WORD_W'(pix_next) << (int'(lane_q) * PIX_W));
    // A write issued last cycle has not yet advanced idx_q
    assign words_now = idx_q + IDX_W'(ram_we_q);

    always_comb begin
        state_d       = state_q;
        cont_d        = cont_q;
        stop_d        = stop_q;
        flush_d       = flush_q;
        drop_d        = drop_q;
        byte_cnt_d    = byte_cnt_q;
        lane_d        = lane_q;
        pix_d         = pix_q;
        word_d        = word_q;
        idx_d         = words_now;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;
        frame_pulse_d = 1'b0;
        overflow_d    = overflow_q;
        frame_words_d = frame_words_q;
        finish        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cap_start) begin
                    state_d    = ST_ARM;
                    cont_d     = cap_continuous;
                    stop_d     = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (cap_stop) begin
                    state_d = ST_IDLE;
                end else if (vsync_s) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cap_stop) begin
                    state_d = ST_IDLE;
                end else if (!vsync_s) begin
                    state_d    = ST_CAPTURE;
                    idx_d      = '0;
                    lane_d     = '0;
                    byte_cnt_d = '0;
                    pix_d      = '0;
                    word_d     = '0;
                    drop_d     = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (cap_stop) begin
                    stop_d = 1'b1;
                end
                if (flush_q) begin
                    finish = 1'b1;
                end else if (vsync_s) begin
                    if (lane_q != '0 && !drop_q) begin
                        if (words_now < IDX_W'(DEPTH)) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = word_q;
                            flush_d     = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                            finish     = 1'b1;
                        end
                    end else begin
                        finish = 1'b1;
                    end
                end else if (!href_s) begin
                    byte_cnt_d = '0;
                end else if (stb && !drop_q) begin
                    pix_d = pix_next;
                    if (byte_cnt_q == BC_W'(BYTES_PER_PIX - 1)) begin
                        byte_cnt_d = '0;
                        if (lane_q == LANE_W'(PPW - 1)) begin
                            lane_d = '0;
                            word_d = '0;
                            if (idx_q < IDX_W'(DEPTH)) begin
                                ram_we_d    = 1'b1;
                                ram_wdata_d = word_ins;
                            end else begin
                                overflow_d = 1'b1;
                                drop_d     = 1'b1;
                            end
                        end else begin
                            lane_d = lane_q + LANE_W'(1);
                            word_d = word_ins;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
                if (finish) begin
                    flush_d       = 1'b0;
                    frame_words_d = words_now;
                    frame_pulse_d = 1'b1;
                    if (!cont_q || stop_q || cap_stop) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SYNC;
                        idx_d   = '0;
                    end
                end
            end
            ST_DONE: begin
                if (cap_start) begin
                    state_d    = ST_ARM;
                    cont_d     = cap_continuous;
                    stop_d     = 1'b0;
                    overflow_d = 1'b0;
                end else if (cap_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
            flush_q       <= 1'b0;
            drop_q        <= 1'b0;
            byte_cnt_q    <= '0;
            lane_q        <= '0;
            pix_q         <= '0;
            word_q        <= '0;
            idx_q         <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            frame_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
            frame_words_q <= '0;
        end else begin
            state_q       <= state_d;
            cont_q        <= cont_d;
            stop_q        <= stop_d;
            flush_q       <= flush_d;
            drop_q        <= drop_d;
            byte_cnt_q    <= byte_cnt_d;
            lane_q        <= lane_d;
            pix_q         <= pix_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            frame_pulse_q <= frame_pulse_d;
            overflow_q    <= overflow_d;
            frame_words_q <= frame_words_d;
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_addr     = idx_q[ADDR_W-1:0];
    assign ram_wdata    = ram_wdata_q;
    assign cap_busy     = (state_q == ST_ARM) || (state_q == ST_SYNC) || (state_q == ST_CAPTURE);
    assign cap_done     = (state_q == ST_DONE);
    assign frame_pulse  = frame_pulse_q;
    assign cap_overflow = overflow_q;
    assign frame_words  = frame_words_q;

endmodule

// File: tb/tb_camera_capture_v2.sv
// tb/tb_camera_capture_v2.sv - scoreboard bench for camera_capture_v2 (default and DEPTH=4 instances)
module tb_camera_capture_v2;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cap_start = 1'b0;
    logic        cap_start_s = 1'b0;
    logic        cap_continuous = 1'b0;
    logic        cap_stop = 1'b0;
    logic        cap_ack = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;

    logic        ram_we, cap_busy, cap_done, frame_pulse, cap_overflow;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [16:0] frame_words;
    logic        ram_we_s, cap_busy_s, cap_done_s, frame_pulse_s, cap_overflow_s;
    logic [15:0] ram_addr_s;
    logic [31:0] ram_wdata_s;
    logic [16:0] frame_words_s;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          pulses = 0;
    int          pulses_s = 0;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    wr_t         exp_s[$];
    wr_t         obs_s[$];

    bit          m_on = 1'b0;
    bit          m_small = 1'b0;
    bit          m_drop = 1'b0;
    int          m_lane = 0;
    int          m_addr = 0;
    int          m_depth = 38400;
    int          m_words = 0;
    logic [31:0] m_word = 32'h0;
    logic [7:0]  nb = 8'h01;

    always #5 HCLK = ~HCLK;

    camera_capture_v2 dut (
        .HCLK(HCLK), .HRESET(HRESET), .cap_start(cap_start), .cap_continuous(cap_continuous),
        .cap_stop(cap_stop), .cap_ack(cap_ack), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cap_busy(cap_busy), .cap_done(cap_done), .frame_pulse(frame_pulse),
        .cap_overflow(cap_overflow), .frame_words(frame_words)
    );

    camera_capture_v2 #(.DEPTH(4)) dut_small (
        .HCLK(HCLK), .HRESET(HRESET), .cap_start(cap_start_s), .cap_continuous(cap_continuous),
        .cap_stop(cap_stop), .cap_ack(cap_ack), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .ram_we(ram_we_s), .ram_addr(ram_addr_s),
        .ram_wdata(ram_wdata_s), .cap_busy(cap_busy_s), .cap_done(cap_done_s), .frame_pulse(frame_pulse_s),
        .cap_overflow(cap_overflow_s), .frame_words(frame_words_s)
    );

    task automatic tick();
        wr_t w;
        @(negedge HCLK);
        if (ram_we) begin
            w.a = ram_addr; w.d = ram_wdata; obs_q.push_back(w);
        end
        if (ram_we_s) begin
            w.a = ram_addr_s; w.d = ram_wdata_s; obs_s.push_back(w);
        end
        if (frame_pulse) pulses++;
        if (frame_pulse_s) pulses_s++;
    endtask

    task automatic pulse_start(input logic cont);
        cap_continuous = cont; cap_start = 1'b1; tick(); cap_start = 1'b0;
    endtask

    task automatic model_push();
        wr_t w;
        w.a = m_addr[15:0]; w.d = m_word;
        if (m_small) exp_s.push_back(w);
        else exp_q.push_back(w);
        m_addr++;
    endtask

    task automatic model_pixel(input logic [15:0] p);
        if (m_on && !m_drop) begin
            m_word = m_word | (32'(p) << (16 * m_lane));
            m_lane++;
            if (m_lane == 2) begin
                if (m_addr < m_depth) model_push();
                else m_drop = 1'b1;
                m_lane = 0; m_word = 32'h0;
            end
        end
    endtask

    task automatic cam_cycle(input logic href, input logic [7:0] d);
        cam_href = href; cam_data = d; cam_pclk = 1'b0;
        repeat (4) tick();
        cam_pclk = 1'b1;
        repeat (4) tick();
    endtask

    task automatic frame_begin();
        cam_vsync = 1'b1;
        repeat (2) cam_cycle(1'b0, 8'h00);
        cam_vsync = 1'b0;
        if (m_on) begin
            m_addr = 0; m_lane = 0; m_word = 32'h0; m_drop = 1'b0;
        end
        repeat (2) cam_cycle(1'b0, 8'h00);
    endtask

    task automatic send_line(input int npix);
        logic [7:0] b0, b1;
        for (int i = 0; i < npix; i++) begin
            b0 = nb; b1 = nb + 8'd1; nb = nb + 8'd2;
            cam_cycle(1'b1, b0);
            cam_cycle(1'b1, b1);
            model_pixel({b0, b1});
        end
        repeat (2) cam_cycle(1'b0, 8'h00);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        if (m_on) begin
            if (m_lane != 0 && !m_drop && m_addr < m_depth) model_push();
            m_lane = 0; m_word = 32'h0;
            m_words = m_addr;
        end
        repeat (3) cam_cycle(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({ram_we, ram_addr, ram_wdata, frame_words} !== '0)
            $display("FAIL reset_datapath got we=%0b addr=%0h data=%0h fw=%0d exp all 0", ram_we, ram_addr, ram_wdata, frame_words);
        else pass_cnt++;
        total_cnt++;
        if ({cap_busy, cap_done, frame_pulse, cap_overflow} !== 4'b0000)
            $display("FAIL reset_status got=%b exp=0000", {cap_busy, cap_done, frame_pulse, cap_overflow});
        else pass_cnt++;
        total_cnt++;
        if ({ram_we_s, cap_busy_s, cap_done_s, cap_overflow_s, frame_words_s} !== '0)
            $display("FAIL reset_small got busy=%0b done=%0b ovf=%0b fw=%0d exp 0", cap_busy_s, cap_done_s, cap_overflow_s, frame_words_s);
        else pass_cnt++;
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        wr_t e, o;
        logic [31:0] w0;
        exp_q.delete(); obs_q.delete(); pulses = 0;
        m_on = 1'b1; m_small = 1'b0; m_depth = 38400; nb = 8'h01;
        pulse_start(1'b0);
        frame_begin();
        send_line(4);
        send_line(4);
        frame_end();
        w0 = (obs_q.size() > 0) ? obs_q[0].d : 32'hxxxxxxxx;
        total_cnt++;
        if (w0 !== 32'h03040102) $display("FAIL t1_word0 got=%h exp=03040102", w0); else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL t1_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t1_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_words !== 17'(m_words) || m_words != 4) $display("FAIL t1_frame_words got=%0d exp=4", frame_words);
        else pass_cnt++;
        total_cnt++;
        if (cap_done !== 1'b1 || cap_busy !== 1'b0) $display("FAIL t1_done got done=%0b busy=%0b exp done=1 busy=0", cap_done, cap_busy);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 1) $display("FAIL t1_pulses got=%0d exp=1", pulses); else pass_cnt++;
        cap_ack = 1'b1; tick(); cap_ack = 1'b0; tick();
        total_cnt++;
        if (cap_done !== 1'b0) $display("FAIL t1_ack got done=%0b exp=0", cap_done); else pass_cnt++;
    endtask

    task automatic test_odd_pixels();
        wr_t e, o;
        exp_q.delete(); obs_q.delete();
        m_on = 1'b1; m_small = 1'b0; nb = 8'h11;
        pulse_start(1'b0);
        frame_begin();
        send_line(3);
        frame_end();
        total_cnt++;
        if (obs_q.size() != 2 || exp_q.size() != 2) $display("FAIL t2_write_count got=%0d exp=2", obs_q.size());
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() == 2 && obs_q[1].d[31:16] !== 16'h0000) $display("FAIL t2_flush_upper got=%h exp=0000", obs_q[1].d[31:16]);
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t2_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_words !== 17'd2) $display("FAIL t2_frame_words got=%0d exp=2", frame_words); else pass_cnt++;
        cap_ack = 1'b1; tick(); cap_ack = 1'b0; tick();
    endtask

    task automatic test_overflow();
        wr_t e, o;
        exp_s.delete(); obs_s.delete(); obs_q.delete(); pulses_s = 0;
        m_on = 1'b1; m_small = 1'b1; m_depth = 4; nb = 8'h30;
        cap_continuous = 1'b0; cap_start_s = 1'b1; tick(); cap_start_s = 1'b0;
        frame_begin();
        send_line(6);
        send_line(6);
        frame_end();
        total_cnt++;
        if (obs_s.size() != 4 || exp_s.size() != 4) $display("FAIL t3_write_count got=%0d exp=4", obs_s.size());
        else pass_cnt++;
        while (exp_s.size() > 0 && obs_s.size() > 0) begin
            e = exp_s.pop_front(); o = obs_s.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t3_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (cap_overflow_s !== 1'b1 || frame_words_s !== 17'd4) $display("FAIL t3_overflow got ovf=%0b fw=%0d exp ovf=1 fw=4", cap_overflow_s, frame_words_s);
        else pass_cnt++;
        total_cnt++;
        if (pulses_s != 1 || cap_done_s !== 1'b1) $display("FAIL t3_done got pulses=%0d done=%0b exp 1 1", pulses_s, cap_done_s);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL t3_idle_dut_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
        cap_start_s = 1'b1; tick(); cap_start_s = 1'b0; tick();
        total_cnt++;
        if (cap_overflow_s !== 1'b0) $display("FAIL t3_ovf_clear got=%0b exp=0", cap_overflow_s); else pass_cnt++;
        repeat (4) tick();
        cap_stop = 1'b1; tick(); cap_stop = 1'b0; tick();
        total_cnt++;
        if (cap_busy_s !== 1'b0) $display("FAIL t3_stop_idle got busy=%0b exp=0", cap_busy_s); else pass_cnt++;
        m_small = 1'b0; m_depth = 38400;
    endtask

    task automatic test_continuous();
        wr_t e, o;
        exp_q.delete(); obs_q.delete(); pulses = 0;
        m_on = 1'b1; m_small = 1'b0; nb = 8'h20;
        pulse_start(1'b1);
        cap_continuous = 1'b0;
        frame_begin();
        send_line(4);
        frame_end();
        nb = 8'h40;
        frame_begin();
        send_line(4);
        cap_stop = 1'b1; tick(); cap_stop = 1'b0;
        send_line(4);
        frame_end();
        m_on = 1'b0; nb = 8'h60;
        frame_begin();
        send_line(4);
        frame_end();
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL t4_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t4_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (pulses != 2) $display("FAIL t4_pulses got=%0d exp=2", pulses); else pass_cnt++;
        total_cnt++;
        if (cap_done !== 1'b1 || frame_words !== 17'd4) $display("FAIL t4_done got done=%0b fw=%0d exp 1 4", cap_done, frame_words);
        else pass_cnt++;
        cap_ack = 1'b1; tick(); cap_ack = 1'b0; tick();
    endtask

    task automatic test_mid_frame_start();
        wr_t e, o;
        exp_q.delete(); obs_q.delete();
        cam_vsync = 1'b0;
        repeat (2) cam_cycle(1'b0, 8'h00);
        m_on = 1'b0; nb = 8'h70;
        pulse_start(1'b0);
        send_line(2);
        m_on = 1'b1; nb = 8'h80;
        frame_begin();
        send_line(2);
        frame_end();
        total_cnt++;
        if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL t5_write_count got=%0d exp=1", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t5_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_words !== 17'd1 || cap_done !== 1'b1) $display("FAIL t5_frame got fw=%0d done=%0b exp 1 1", frame_words, cap_done);
        else pass_cnt++;
        obs_q.delete();
        pulse_start(1'b0);
        repeat (6) tick();
        total_cnt++;
        if (cap_busy !== 1'b1 || cap_done !== 1'b0) $display("FAIL t5_rearm got busy=%0b done=%0b exp 1 0", cap_busy, cap_done);
        else pass_cnt++;
        cap_stop = 1'b1; tick(); cap_stop = 1'b0; tick();
        total_cnt++;
        if (cap_busy !== 1'b0 || cap_done !== 1'b0 || frame_pulse !== 1'b0) $display("FAIL t5_sync_stop got busy=%0b done=%0b exp 0 0", cap_busy, cap_done);
        else pass_cnt++;
        m_on = 1'b0;
        frame_begin();
        send_line(2);
        frame_end();
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL t5_idle_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        wr_t e, o;
        exp_q.delete(); obs_q.delete();
        m_on = 1'b1; nb = 8'h90;
        pulse_start(1'b0);
        frame_begin();
        send_line(3);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        total_cnt++;
        if ({ram_we, ram_addr, ram_wdata, frame_words} !== '0)
            $display("FAIL t6_reset_datapath got we=%0b addr=%0h data=%0h fw=%0d exp all 0", ram_we, ram_addr, ram_wdata, frame_words);
        else pass_cnt++;
        total_cnt++;
        if ({cap_busy, cap_done, frame_pulse, cap_overflow} !== 4'b0000)
            $display("FAIL t6_reset_status got=%b exp=0000", {cap_busy, cap_done, frame_pulse, cap_overflow});
        else pass_cnt++;
        repeat (2) tick();
        HRESET = 1'b0;
        m_on = 1'b0;
        frame_end();
        total_cnt++;
        if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL t6_write_count got=%0d exp=1", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL t6_write got=%0h:%h exp=%0h:%h", o.a, o.d, e.a, e.d);
            else pass_cnt++;
        end
        total_cnt++;
        if (cap_busy !== 1'b0) $display("FAIL t6_idle_after got busy=%0b exp=0", cap_busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_odd_pixels();
        test_overflow();
        test_continuous();
        test_mid_frame_start();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/camera_capture_v2.md
Name: camera_capture_v2

Overview:
Parametrised successor to the single-frame camera capture path, clocked entirely in the HCLK domain. Camera pins are synchronised and PCLK rising edges are detected as sample strobes. Bytes are assembled into pixels, and pixels are packed into RAM words. Single-shot and continuous capture modes are supported, with overflow protection and a per-frame word count for the CPU-side driver.

Parameters:
DATA_W, 8, camera data bus width in bits.
BYTES_PER_PIX, 2, camera bytes per pixel.
WORD_W, 32, RAM word width; must be a multiple of DATA_W*BYTES_PER_PIX.
DEPTH, 38400, frame buffer depth in words.
ADDR_W, 16, RAM address width; must be at least clog2(DEPTH).

Ports:
HCLK  in  1  system clock; the only clock.
HRESET  in  1  reset, synchronous, active-high.
cap_start  in  1  one-cycle pulse that arms a capture.
cap_continuous  in  1  mode select, sampled on cap_start: 1 = continuous, 0 = single-shot.
cap_stop  in  1  pulse that ends continuous capture at the next frame end, or aborts a pre-capture state.
cap_ack  in  1  clears cap_done and returns the block to IDLE.
cam_pclk  in  1  camera pixel clock, sampled as data.
cam_vsync  in  1  frame sync; high between frames.
cam_href  in  1  line valid.
cam_data  in  DATA_W  camera byte.
ram_we  out  1  RAM write strobe.
ram_addr  out  ADDR_W  RAM word address.
ram_wdata  out  WORD_W  RAM write data.
cap_busy  out  1  high in ARM, SYNC and CAPTURE.
cap_done  out  1  level; high in DONE.
frame_pulse  out  1  one-cycle pulse at the end of every captured frame.
cap_overflow  out  1  sticky; cleared by cap_start.
frame_words  out  ADDR_W+1  words written in the last completed frame.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and all counters and the packing register are 0.
- Input conditioning:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through an identical 2-FF synchroniser.
  - A strobe (stb) fires when pclk_s2=1 and pclk_s3=0.
  - vsync_s, href_s and data_s are the stage-2 values, aligned with stb.
  - HCLK must be at least 4x the camera PCLK frequency.
- Pixel assembly:
  - On stb with href_s=1, data_s is captured and the byte count increments. The first byte of a pixel lands in the most-significant byte.
  - href_s=0 resets the byte count. A partial pixel at line end is discarded.
- Packing:
  - PIX_PER_WORD = WORD_W/(DATA_W*BYTES_PER_PIX).
  - Pixel k of a word occupies bits [k*PIX_W +: PIX_W]; pixel 0 is the LSBs.
  - Lane fill carries across lines.
- Write timing:
  - When a word completes, ram_we is high for exactly 1 cycle, on the cycle after the stb that supplied the last byte.
  - ram_addr equals the current word index and increments after the write.
- FSM states:
  - IDLE: cap_start latches the mode, clears cap_overflow, and moves to ARM.
  - ARM: waits for vsync_s=1, then moves to SYNC.
  - SYNC: waits for vsync_s=0; then clears the address, lane and byte counters and moves to CAPTURE.
  - CAPTURE: pixels are accepted. vsync_s=1 ends the frame.
  - DONE: cap_ack moves to IDLE; cap_start moves to ARM and clears cap_done.
- Frame end (in CAPTURE):
  - A partially filled word is flushed with its unused lanes set to 0, taking one extra write cycle.
  - frame_words is then updated and frame_pulse fires.
  - Single-shot mode, or continuous mode with a pending stop, moves to DONE. Otherwise the block moves to SYNC and the address restarts at 0.
- cap_stop handling:
  - In ARM or SYNC, cap_stop goes to IDLE with no pulse.
  - In CAPTURE, cap_stop is latched and acted on at frame end.
  - In IDLE or DONE, cap_stop is ignored.
- cap_start while cap_busy=1 is ignored.
- Overflow: a word completing when the index equals DEPTH is not written, and cap_overflow is set. Further data in the frame is dropped, and frame_words saturates at DEPTH.
- Simultaneous events:
  - A frame-end vsync takes priority over an stb in the same cycle; that stb's data is dropped.
  - cap_ack together with cap_start in DONE: cap_start wins.
- Reset mid-frame: the block returns to IDLE immediately and no flush occurs.

Decomposition:
- Package camera_pkg: FSM state encoding (IDLE, ARM, SYNC, CAPTURE, DONE), the PIX_W and PIX_PER_WORD derivation functions, and a clog2 function.
- Sub-module cam_pin_sync: the synchroniser plus PCLK edge detect, emitting stb, vsync_s, href_s and data_s.
- The FSM and packer stay in the top module.

Test Plan:
1. Defaults, single-shot: one frame of 2 lines x 4 pixels, bytes 0x01..0x10 -> 4 writes, addr 0..3. Word0=0x03040102, frame_words=4, cap_done=1, exactly one frame_pulse.
2. Odd pixel count: 3 pixels total -> 2 writes; the second word has 0x0000 in the upper half. frame_words=2.
3. DEPTH=4, a frame of 12 pixels -> writes only to addr 0..3, cap_overflow=1, frame_words=4. The next cap_start clears cap_overflow.
4. Continuous mode, 3 frames, cap_stop pulsed during frame 2 -> 2 frame_pulses, then DONE. Each frame starts at addr 0; no frame-3 writes.
5. Start mid-frame (cap_start while vsync low) -> the partial frame is ignored and capture begins at the next vsync falling edge. cap_stop in SYNC -> IDLE, ram_we never asserted.
6. HRESET asserted mid-CAPTURE -> the next cycle shows all outputs 0 and state IDLE; no flush write occurs.
